// File: rtl/divider_loader_if.sv
// Handshake and serial-shift signals between a target source and divider_loader.
interface divider_loader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] target_value;
    logic                  target_valid;
    logic                  target_ready;
    logic                  load_done;
    logic                  load_error;
    logic                  sr_data;
    logic                  sr_data_clock;
    logic                  sr_div_data_enable;
    logic                  sr_div_data_reset;

    modport master (
        output target_value, target_valid,
        input  target_ready, load_done, load_error,
        input  sr_data, sr_data_clock, sr_div_data_enable, sr_div_data_reset
    );

    modport slave (
        input  target_value, target_valid,
        output target_ready, load_done, load_error,
        output sr_data, sr_data_clock, sr_div_data_enable, sr_div_data_reset
    );
endinterface

// File: rtl/divider_loader.sv
// Serially loads a divide target into a downstream shift register, MSB first.
// Optional macro LOADER_ZERO_GUARD_EN rejects targets below 2 with a load_error pulse.
module divider_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLK_DIV    = 4
) (
    input logic             system_clock,
    input logic             external_reset,
    divider_loader_if.slave ldr
);
    localparam int unsigned     CntW      = $clog2(2 * CLK_DIV + 1);
    localparam int unsigned     BitW      = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] ClearLast = CntW'(CLK_DIV);
    localparam logic [CntW-1:0] LowLast   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] BitLast   = CntW'(2 * CLK_DIV - 1);
    localparam logic [BitW-1:0] LastBit   = BitW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [BitW-1:0]       bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  data_q;
    logic                  sclk_q;
    logic                  enable_q;
    logic                  clear_q;
`ifdef LOADER_ZERO_GUARD_EN
    logic                  error_q;
`endif

    always_ff @(posedge system_clock or posedge external_reset) begin
        if (external_reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            data_q   <= 1'b0;
            sclk_q   <= 1'b0;
            enable_q <= 1'b0;
            clear_q  <= 1'b0;
`ifdef LOADER_ZERO_GUARD_EN
            error_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef LOADER_ZERO_GUARD_EN
            error_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (ldr.target_valid && ready_q) begin
                        shift_q <= ldr.target_value;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= StClear;
`ifdef LOADER_ZERO_GUARD_EN
                        error_q <= (ldr.target_value < DATA_WIDTH'(2));
`endif
                    end
                end
                StClear: begin
                    // First CLEAR cycle is the capture slot; the clear pulse follows it.
                    if (cnt_q == ClearLast) begin
                        clear_q  <= 1'b0;
                        enable_q <= 1'b1;
                        data_q   <= shift_q[DATA_WIDTH-1];
                        shift_q  <= shift_q << 1;
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        state_q  <= StShift;
                    end else begin
                        clear_q <= 1'b1;
                        cnt_q   <= cnt_q + 1'b1;
                    end
`ifdef LOADER_ZERO_GUARD_EN
                    if (error_q) begin
                        clear_q <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
`endif
                end
                StShift: begin
                    if (cnt_q == BitLast) begin
                        sclk_q <= 1'b0;
                        cnt_q  <= '0;
                        if (bit_q == LastBit) begin
                            enable_q <= 1'b0;
                            data_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            data_q  <= shift_q[DATA_WIDTH-1];
                            shift_q <= shift_q << 1;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end else begin
                        if (cnt_q == LowLast) sclk_q <= 1'b1;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ldr.target_ready       = ready_q;
    assign ldr.load_done          = done_q;
    assign ldr.sr_data            = data_q;
    assign ldr.sr_data_clock      = sclk_q;
    assign ldr.sr_div_data_enable = enable_q;
    assign ldr.sr_div_data_reset  = clear_q;
`ifdef LOADER_ZERO_GUARD_EN
    assign ldr.load_error         = error_q;
`else
    assign ldr.load_error         = 1'b0;
`endif
endmodule
